// File: rtl/ws2812_pkg.sv
// Shared types and helpers for the WS2812 frame driver: FSM states, timing conversion, GRB packing, brightness scaling.
// Pure package, no latency or backpressure of its own.
package ws2812_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_GAP
    } state_t;

    localparam int PIX_W = 24;

    function automatic int ns_to_cyc(input int clk_freq, input int ns);
        return clk_freq / 1_000_000 * ns / 1000;
    endfunction

    function automatic int us_to_cyc(input int clk_freq, input int us);
        return clk_freq / 1_000_000 * us;
    endfunction

    function automatic logic [PIX_W-1:0] pack_grb(input logic [7:0] r,
                                                   input logic [7:0] g,
                                                   input logic [7:0] b);
        return {g, r, b};
    endfunction

    // (c * (br + 1)) >> 8: 255 is the identity, 0 blanks the channel.
    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] br);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, br} + 16'd1);
        return 8'(prod >> 8);
    endfunction

    function automatic logic [PIX_W-1:0] scale_grb(input logic [PIX_W-1:0] grb,
                                                   input logic [7:0] br);
        return {scale8(grb[23:16], br), scale8(grb[15:8], br), scale8(grb[7:0], br)};
    endfunction

endpackage

// File: rtl/ws2812_pix_ram.sv
// Pixel frame buffer: one write port, one registered read port, read-before-write.
// Read data valid one cycle after the address edge; never stalls.
module ws2812_pix_ram
    import ws2812_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [PIX_W-1:0] wr_dat_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [PIX_W-1:0] rd_dat_o
);

    logic [PIX_W-1:0] mem [DEPTH];
    logic [PIX_W-1:0] rd_q;

    // No reset: contents are meant to survive a logic reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_dat_i;
        end
        rd_q <= mem[rd_addr_i];
    end

    assign rd_dat_o = rd_q;

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// WS2812 frame driver: buffers LED_NUM pixels, scales by brightness, serialises GRB MSB-first then holds the latch gap.
// LED line rises two edges after frame_start is taken; frame_start is ignored while busy, writes are always accepted.
module ws2812_frame_ctrl
    import ws2812_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int LED_NUM  = 64,
    parameter int T0H_NS   = 400,
    parameter int T1H_NS   = 800,
    parameter int BIT_NS   = 1250,
    parameter int RST_US   = 280,
    localparam int AW      = (LED_NUM > 1) ? $clog2(LED_NUM) : 1
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_r,
    input  logic [7:0]    wr_g,
    input  logic [7:0]    wr_b,
    input  logic [7:0]    brightness,
    input  logic          frame_start,
    output logic          busy,
    output logic          frame_done,
    output logic          led_data
);

    localparam int T0H_CYC = ns_to_cyc(CLK_FREQ, T0H_NS);
    localparam int T1H_CYC = ns_to_cyc(CLK_FREQ, T1H_NS);
    localparam int BIT_CYC = ns_to_cyc(CLK_FREQ, BIT_NS);
    localparam int RST_CYC = us_to_cyc(CLK_FREQ, RST_US);
    localparam int CW      = $clog2(RST_CYC + 1);

    localparam logic [CW-1:0] T0H_C    = CW'(T0H_CYC);
    localparam logic [CW-1:0] T1H_C    = CW'(T1H_CYC);
    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYC - 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(LED_NUM - 1);
    localparam logic [AW:0]   NUM_W    = (AW + 1)'(LED_NUM);

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [4:0]       bit_q, bit_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PIX_W-1:0] sh_q, sh_d;
    logic [7:0]       bri_q, bri_d;
    logic             led_q, led_d;
    logic             done_q, done_d;
    logic             byp_vld_q;
    logic [PIX_W-1:0] byp_dat_q;

    logic             wr_ok;
    logic [PIX_W-1:0] wr_dat;
    logic [PIX_W-1:0] ram_rd;
    logic [PIX_W-1:0] pix;
    logic [CW-1:0]    cnt_inc;
    logic [CW-1:0]    hi_len;

    assign wr_ok   = wr_en && ({1'b0, wr_addr} < NUM_W);
    assign wr_dat  = pack_grb(wr_r, wr_g, wr_b);
    assign cnt_inc = cnt_q + CW'(1);
    assign hi_len  = sh_q[PIX_W-1] ? T1H_C : T0H_C;

    // Read address follows next-state index so data is ready during LOAD.
    ws2812_pix_ram #(
        .DEPTH (LED_NUM),
        .AW    (AW)
    ) u_ram (
        .clk_i     (sys_clk),
        .wr_en_i   (wr_ok),
        .wr_addr_i (wr_addr),
        .wr_dat_i  (wr_dat),
        .rd_addr_i (idx_d),
        .rd_dat_o  (ram_rd)
    );

    // A write landing on the same edge as the RAM read would be missed by
    // the read-before-write port; forward it so "not yet loaded" holds.
    assign pix = byp_vld_q ? byp_dat_q : ram_rd;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        bri_d   = bri_q;
        led_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    bri_d   = brightness;
                    idx_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                sh_d    = scale_grb(pix, bri_q);
                bit_d   = '0;
                cnt_d   = '0;
                led_d   = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 5'd23) begin
                        if (idx_q != LAST_IDX) begin
                            idx_d   = idx_q + AW'(1);
                            state_d = ST_LOAD;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else begin
                        bit_d = bit_q + 5'd1;
                        sh_d  = sh_q << 1;
                        led_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    led_d = (cnt_inc < hi_len);
                end
            end
            ST_GAP: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            bit_q     <= '0;
            cnt_q     <= '0;
            sh_q      <= '0;
            bri_q     <= '0;
            led_q     <= 1'b0;
            done_q    <= 1'b0;
            byp_vld_q <= 1'b0;
            byp_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            bit_q     <= bit_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            bri_q     <= bri_d;
            led_q     <= led_d;
            done_q    <= done_d;
            byp_vld_q <= wr_ok && (wr_addr == idx_d);
            byp_dat_q <= wr_dat;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign frame_done = done_q;
    assign led_data   = led_q;

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Directed bench for ws2812_frame_ctrl: a 2-pixel 50 MHz instance and a 1-pixel 100 MHz instance.
module tb_ws2812_frame_ctrl;

    logic sys_clk = 1'b0;
    logic clk1    = 1'b0;
    always #5 sys_clk = ~sys_clk;
    always #1 clk1    = ~clk1;

    logic       rst_n;
    logic       wr_en0, fs0, busy0, done0, led0;
    logic [0:0] wr_addr0;
    logic [7:0] wr_r0, wr_g0, wr_b0, bri0;
    logic       wr_en1, fs1, busy1, done1, led1;
    logic [0:0] wr_addr1;
    logic [7:0] wr_r1, wr_g1, wr_b1, bri1;

    ws2812_frame_ctrl #(.CLK_FREQ(50_000_000), .LED_NUM(2)) dut0 (
        .sys_clk(sys_clk), .sys_rst_n(rst_n), .wr_en(wr_en0), .wr_addr(wr_addr0),
        .wr_r(wr_r0), .wr_g(wr_g0), .wr_b(wr_b0), .brightness(bri0),
        .frame_start(fs0), .busy(busy0), .frame_done(done0), .led_data(led0));

    ws2812_frame_ctrl #(.CLK_FREQ(100_000_000), .LED_NUM(1)) dut1 (
        .sys_clk(clk1), .sys_rst_n(rst_n), .wr_en(wr_en1), .wr_addr(wr_addr1),
        .wr_r(wr_r1), .wr_g(wr_g1), .wr_b(wr_b1), .brightness(bri1),
        .frame_start(fs1), .busy(busy1), .frame_done(done1), .led_data(led1));

    int n_cmp = 0;
    int n_err = 0;
    int cyc0 = 0, cyc1 = 0, done_cnt0 = 0, done_cnt1 = 0;
    int hw_log [24];
    logic [23:0] rx_val;
    int t_fall;

    always @(posedge sys_clk) begin
        cyc0 <= cyc0 + 1;
        if (done0 === 1'b1) done_cnt0 <= done_cnt0 + 1;
    end
    always @(posedge clk1) begin
        cyc1 <= cyc1 + 1;
        if (done1 === 1'b1) done_cnt1 <= done_cnt1 + 1;
    end

    task automatic tick(input bit sel);
        if (sel) @(negedge clk1);
        else     @(negedge sys_clk);
    endtask

    function automatic logic led_of(input bit sel);
        return sel ? led1 : led0;
    endfunction

    task automatic wr0(input logic a, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        wr_en0 = 1'b1; wr_addr0 = a; wr_r0 = r; wr_g0 = g; wr_b0 = b;
        tick(0);
        wr_en0 = 1'b0;
    endtask

    task automatic wr1(input logic a, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        wr_en1 = 1'b1; wr_addr1 = a; wr_r1 = r; wr_g1 = g; wr_b1 = b;
        tick(1);
        wr_en1 = 1'b0;
    endtask

    task automatic start0();
        fs0 = 1'b1; tick(0); fs0 = 1'b0;
    endtask

    task automatic abort0();
        rst_n = 1'b0; tick(0); rst_n = 1'b1; tick(0);
    endtask

    // Receives 24 bits; act 1 re-pulses frame_start, act 2 writes pixels, after bit act_bit.
    task automatic rx_pixel(input bit sel, input int thr, input int act_bit, input int act, output bit ok);
        ok = 1'b1;
        for (int b = 0; b < 24; b++) begin
            int t = 0;
            int hw = 0;
            while (led_of(sel) !== 1'b1 && t < 400) begin tick(sel); t++; end
            if (t >= 400) begin ok = 1'b0; return; end
            while (led_of(sel) === 1'b1 && hw < 400) begin tick(sel); hw++; end
            hw_log[b] = hw;
            rx_val[23-b] = (hw >= thr);
            if (b == act_bit && act == 1) start0();
            if (b == act_bit && act == 2) begin
                wr0(1'b1, 8'h00, 8'hAA, 8'h00);
                wr0(1'b0, 8'h00, 8'h00, 8'h55);
            end
        end
        t_fall = sel ? cyc1 : cyc0;
    endtask

    task automatic wait_done(input bit sel, input int limit, output bit ok, output bit hi_seen);
        int t = 0;
        ok = 1'b1; hi_seen = 1'b0;
        while ((sel ? done1 : done0) !== 1'b1) begin
            if (led_of(sel) === 1'b1) hi_seen = 1'b1;
            if (t >= limit) begin ok = 1'b0; return; end
            tick(sel); t++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick(0);
        n_cmp++; if (led0 !== 1'b0)  begin n_err++; $display("FAIL reset_led0 got %b want 0", led0); end
        n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL reset_busy0 got %b want 0", busy0); end
        n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL reset_done0 got %b want 0", done0); end
        n_cmp++; if (led1 !== 1'b0)  begin n_err++; $display("FAIL reset_led1 got %b want 0", led1); end
        n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL reset_busy1 got %b want 0", busy1); end
        rst_n = 1'b1;
        tick(0);
    endtask

    task automatic test_frame_basic();
        bit ok, hi;
        int t0, tf, d0, exp_hw;
        wr0(1'b0, 8'hFF, 8'h00, 8'h00);
        wr0(1'b1, 8'h00, 8'h00, 8'h00);
        bri0 = 8'd255;
        d0 = done_cnt0;
        start0();
        t0 = cyc0;
        n_cmp++; if (busy0 !== 1'b1) begin n_err++; $display("FAIL basic_busy_rise got %b want 1", busy0); end
        n_cmp++; if (led0 !== 1'b0)  begin n_err++; $display("FAIL basic_led_in_load got %b want 0", led0); end
        tick(0);
        n_cmp++; if (led0 !== 1'b1)  begin n_err++; $display("FAIL basic_led_rise got %b want 1", led0); end
        rx_pixel(0, 30, 4, 1, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_px0_timeout got 0 want 1"); end
        n_cmp++; if (rx_val !== 24'h00FF00) begin n_err++; $display("FAIL basic_px0 got %h want 00ff00", rx_val); end
        for (int i = 0; i < 24; i++) begin
            exp_hw = (i >= 8 && i < 16) ? 40 : 20;
            n_cmp++;
            if (hw_log[i] != exp_hw) begin n_err++; $display("FAIL basic_hw[%0d] got %0d want %0d", i, hw_log[i], exp_hw); end
        end
        rx_pixel(0, 30, -1, 0, ok);
        n_cmp++; if (!ok || rx_val !== 24'h000000) begin n_err++; $display("FAIL basic_px1 got %h want 000000", rx_val); end
        tf = t_fall;
        wait_done(0, 20000, ok, hi);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_done_timeout got 0 want 1"); end
        n_cmp++; if (cyc0 - t0 != 16978) begin n_err++; $display("FAIL basic_frame_len got %0d want 16978", cyc0 - t0); end
        n_cmp++; if (cyc0 - tf != 14042) begin n_err++; $display("FAIL basic_gap got %0d want 14042", cyc0 - tf); end
        n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL basic_busy_at_done got %b want 0", busy0); end
        repeat (40) tick(0);
        n_cmp++; if (done_cnt0 - d0 != 1) begin n_err++; $display("FAIL basic_done_count got %0d want 1", done_cnt0 - d0); end
        n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL basic_busy_after got %b want 0", busy0); end
    endtask

    task automatic test_brightness();
        bit ok;
        int bad;
        bri0 = 8'd127;
        start0();
        rx_pixel(0, 30, -1, 0, ok);
        n_cmp++; if (!ok || rx_val !== 24'h007F00) begin n_err++; $display("FAIL bri127_px0 got %h want 007f00", rx_val); end
        abort0();
        bri0 = 8'd0;
        start0();
        rx_pixel(0, 30, -1, 0, ok);
        n_cmp++; if (!ok || rx_val !== 24'h000000) begin n_err++; $display("FAIL bri0_px0 got %h want 000000", rx_val); end
        bad = 0;
        for (int i = 0; i < 24; i++) if (hw_log[i] != 20) bad++;
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL bri0_hw got %0d non-20 pulses want 0", bad); end
        abort0();
    endtask

    task automatic test_write_during_frame();
        bit ok;
        bri0 = 8'd255;
        start0();
        rx_pixel(0, 30, 5, 2, ok);
        n_cmp++; if (!ok || rx_val !== 24'h00FF00) begin n_err++; $display("FAIL wr_px0_this_frame got %h want 00ff00", rx_val); end
        rx_pixel(0, 30, -1, 0, ok);
        n_cmp++; if (!ok || rx_val !== 24'hAA0000) begin n_err++; $display("FAIL wr_px1_this_frame got %h want aa0000", rx_val); end
        abort0();
        start0();
        rx_pixel(0, 30, -1, 0, ok);
        n_cmp++; if (!ok || rx_val !== 24'h000055) begin n_err++; $display("FAIL wr_px0_next_frame got %h want 000055", rx_val); end
        abort0();
    endtask

    task automatic test_reset_mid_frame();
        bit ok, hi;
        int t, t0, d0;
        bri0 = 8'd255;
        start0();
        repeat (100) tick(0);
        t = 0;
        while (led0 !== 1'b1 && t < 100) begin tick(0); t++; end
        n_cmp++; if (led0 !== 1'b1) begin n_err++; $display("FAIL rstmid_led_high got %b want 1", led0); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (led0 !== 1'b0)  begin n_err++; $display("FAIL rstmid_led got %b want 0", led0); end
        n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy0); end
        n_cmp++; if (done0 !== 1'b0) begin n_err++; $display("FAIL rstmid_done got %b want 0", done0); end
        repeat (3) tick(0);
        rst_n = 1'b1;
        tick(0);
        d0 = done_cnt0;
        start0();
        t0 = cyc0;
        rx_pixel(0, 30, -1, 0, ok);
        n_cmp++; if (!ok || rx_val !== 24'h000055) begin n_err++; $display("FAIL rstmid_px0 got %h want 000055", rx_val); end
        rx_pixel(0, 30, -1, 0, ok);
        n_cmp++; if (!ok || rx_val !== 24'hAA0000) begin n_err++; $display("FAIL rstmid_px1 got %h want aa0000", rx_val); end
        wait_done(0, 20000, ok, hi);
        n_cmp++; if (!ok || cyc0 - t0 != 16978) begin n_err++; $display("FAIL rstmid_frame_len got %0d want 16978", cyc0 - t0); end
        tick(0);
        n_cmp++; if (done_cnt0 - d0 != 1) begin n_err++; $display("FAIL rstmid_done_count got %0d want 1", done_cnt0 - d0); end
    endtask

    task automatic test_single_led();
        bit ok, hi;
        int t0, tf, d1;
        tick(1);
        wr1(1'b0, 8'h00, 8'h80, 8'h01);
        wr1(1'b1, 8'hFF, 8'hFF, 8'hFF);
        bri1 = 8'd255;
        d1 = done_cnt1;
        fs1 = 1'b1; tick(1); fs1 = 1'b0;
        t0 = cyc1;
        n_cmp++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL one_busy got %b want 1", busy1); end
        rx_pixel(1, 60, -1, 0, ok);
        n_cmp++; if (!ok || rx_val !== 24'h800001) begin n_err++; $display("FAIL one_px0 got %h want 800001", rx_val); end
        n_cmp++; if (hw_log[0] != 80)  begin n_err++; $display("FAIL one_hw0 got %0d want 80", hw_log[0]); end
        n_cmp++; if (hw_log[1] != 40)  begin n_err++; $display("FAIL one_hw1 got %0d want 40", hw_log[1]); end
        n_cmp++; if (hw_log[23] != 80) begin n_err++; $display("FAIL one_hw23 got %0d want 80", hw_log[23]); end
        tf = t_fall;
        wait_done(1, 40000, ok, hi);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL one_done_timeout got 0 want 1"); end
        n_cmp++; if (hi) begin n_err++; $display("FAIL one_extra_pulse got 1 want 0"); end
        n_cmp++; if (cyc1 - t0 != 31001) begin n_err++; $display("FAIL one_frame_len got %0d want 31001", cyc1 - t0); end
        n_cmp++; if (cyc1 - tf != 28045) begin n_err++; $display("FAIL one_gap got %0d want 28045", cyc1 - tf); end
        repeat (10) tick(1);
        n_cmp++; if (done_cnt1 - d1 != 1) begin n_err++; $display("FAIL one_done_count got %0d want 1", done_cnt1 - d1); end
        n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL one_busy_after got %b want 0", busy1); end
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en0 = 1'b0; wr_addr0 = '0; wr_r0 = '0; wr_g0 = '0; wr_b0 = '0; bri0 = '0; fs0 = 1'b0;
        wr_en1 = 1'b0; wr_addr1 = '0; wr_r1 = '0; wr_g1 = '0; wr_b1 = '0; bri1 = '0; fs1 = 1'b0;
        test_reset();
        test_frame_basic();
        test_brightness();
        test_write_during_frame();
        test_reset_mid_frame();
        test_single_led();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
